uart_core: RTL and testbench

//  Parametrised full-duplex UART: one clock, 16x oversampled RX, valid/ready byte interfaces.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_core.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_core.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: FSM state encodings, oversampling
// constants and the parity helper used by both directions.
package uart_pkg;

  localparam int OVS        = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;

  // Parity bit that goes on the line: even parity gives 0 for an even number of ones.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: modulo-CLK_DIV counter with synchronous clear,
// tick high while the counter sits on its terminal value.
module uart_baud_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == CW'(CLK_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART with 16x oversampled receiver and valid/ready byte ports.
// Optional parity bit enabled by defining UART_PARITY_EN.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1,
  parameter int CLK_DIV   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_out,
  input  logic              rx_in,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_parity_err,
  output logic              rx_frame_err,
  output logic              rx_overrun
`ifdef UART_PARITY_EN
  ,
  input  logic              parity_odd
`endif
);

  // Handshakes: a word moves only in a clk where valid && ready are both high;
  // valid never waits on ready, and a valid that is not taken has no side effect.

  tx_state_t         tx_state;
  logic [DATA_W-1:0] tx_shreg;
  logic [3:0]        tx_ticks;
  logic [3:0]        tx_bit;
  logic              tx_tick;
  logic              tx_bit_end;
`ifdef UART_PARITY_EN
  logic              tx_par;
`endif

  rx_state_t         rx_state;
  logic [1:0]        rx_sync;
  logic              rx_s;
  logic              rx_prev;
  logic [DATA_W-1:0] rx_shreg;
  logic [3:0]        rx_ticks;
  logic [3:0]        rx_bit;
  logic              rx_tick;
  logic              rx_mid;
  logic              rx_bit_end;
`ifdef UART_PARITY_EN
  logic              rx_par_bit;
`endif

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_tx_baud (
    .clk   (clk),
    .reset (reset),
    .clear (tx_state == TX_IDLE),
    .tick  (tx_tick)
  );

  uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_rx_baud (
    .clk   (clk),
    .reset (reset),
    .clear (rx_state == RX_IDLE),
    .tick  (rx_tick)
  );

  assign tx_bit_end = tx_tick && (tx_ticks == 4'(OVS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_out   <= 1'b1;
      tx_ready <= 1'b1;
      tx_shreg <= '0;
      tx_ticks <= '0;
      tx_bit   <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      if (tx_state == TX_IDLE) tx_ticks <= '0;
      else if (tx_tick)        tx_ticks <= tx_ticks + 4'd1;
      case (tx_state)
        TX_IDLE: begin
          if (tx_valid && tx_ready) begin
            tx_shreg <= tx_data;
`ifdef UART_PARITY_EN
            tx_par   <= parity_bit(9'(tx_data), parity_odd);
`endif
            tx_ready <= 1'b0;
            tx_out   <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_out   <= tx_shreg[0];
            tx_shreg <= tx_shreg >> 1;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit == 4'(DATA_W - 1)) begin
              tx_bit   <= '0;
`ifdef UART_PARITY_EN
              tx_out   <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx_out   <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx_out   <= tx_shreg[0];
              tx_shreg <= tx_shreg >> 1;
              tx_bit   <= tx_bit + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_out   <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bit == 4'(STOP_BITS - 1)) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_bit <= tx_bit + 4'd1;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_s       = rx_sync[1];
  assign rx_mid     = rx_tick && (rx_ticks == 4'(MID_SAMPLE - 1));
  assign rx_bit_end = rx_tick && (rx_ticks == 4'(OVS - 1));

  // After the mid-start sample the tick count restarts, so later samples land mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_shreg     <= '0;
      rx_ticks     <= '0;
      rx_bit       <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
      rx_par_bit    <= 1'b0;
`endif
    end else begin
      rx_sync    <= {rx_sync[0], rx_in};
      rx_prev    <= rx_s;
      rx_overrun <= 1'b0;
      if (rx_state == RX_IDLE || (rx_state == RX_START && rx_mid)) rx_ticks <= '0;
      else if (rx_tick)                                           rx_ticks <= rx_ticks + 4'd1;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (rx_mid) begin
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_shreg <= {rx_s, rx_shreg[DATA_W-1:1]};
            if (rx_bit == 4'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
              rx_state <= RX_PARITY;
`else
              rx_state <= RX_STOP;
`endif
            end else begin
              rx_bit <= rx_bit + 4'd1;
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_bit_end) begin
            rx_par_bit <= rx_s;
            rx_state   <= RX_STOP;
          end
        end
`endif
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_state <= RX_IDLE;
            if (!rx_valid || rx_ready) begin
              rx_data      <= rx_shreg;
              rx_frame_err <= !rx_s;
`ifdef UART_PARITY_EN
              rx_parity_err <= rx_par_bit != parity_bit(9'(rx_shreg), parity_odd);
`endif
              rx_valid     <= 1'b1;
            end else begin
              rx_overrun <= 1'b1;
            end
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core (CLK_DIV=4, DATA_W=8, even parity when UART_PARITY_EN).
// Received words are checked through an expected-word queue; TX waveform checked bit by bit.
module tb_uart_core;

  localparam int DATA_W   = 8;
  localparam int CLK_DIV  = 4;
  localparam int BIT_CLKS = 16 * CLK_DIV;
`ifdef UART_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME_BITS = 2 + DATA_W + PAR_EN;
  localparam int W = DATA_W + 2;

  logic              clk;
  logic              reset;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_out;
  logic              rx_in;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_parity_err;
  logic              rx_frame_err;
  logic              rx_overrun;
  logic              parity_odd;
  logic              loop_en;
  logic              rx_drv;

  assign rx_in = loop_en ? tx_out : rx_drv;

  uart_core #(.DATA_W(DATA_W), .STOP_BITS(1), .CLK_DIV(CLK_DIV)) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_data       (tx_data),
    .tx_out        (tx_out),
    .rx_in         (rx_in),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .rx_data       (rx_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
`ifdef UART_PARITY_EN
    .parity_odd    (parity_odd),
`endif
    .rx_overrun    (rx_overrun)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_words = 0;
  int n_overrun = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!reset && rx_overrun) n_overrun++;
    if (!reset && rx_valid && rx_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        check("rx word expected", 32'(0), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check("rx word {pe,fe,data}", 32'({rx_parity_err, rx_frame_err, rx_data}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_send(input logic [7:0] d, input bit push);
    int t = 0;
    while (!tx_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready before send", 32'(tx_ready), 32'(1));
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    if (push) exp_q.push_back({2'b00, d});
  endtask

  task automatic rx_bit(input logic v);
    rx_drv = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop, input logic flip);
    @(negedge clk);
    rx_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) rx_bit(d[i]);
    if (PAR_EN != 0) rx_bit((^d) ^ flip);
    rx_bit(stop);
    rx_drv = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       flip;
    logic       exp_fe;
    logic       exp_pe;
  } rx_vec_t;

  rx_vec_t vecs[4];
  logic [FRAME_BITS-1:0] fb;
  int bad[FRAME_BITS];
  int ready_low;
  int words0;
  int ov0;

  initial begin
    vecs[0] = '{data: 8'h96, stop: 1'b1, flip: 1'b0, exp_fe: 1'b0, exp_pe: 1'b0};
    vecs[1] = '{data: 8'h41, stop: 1'b0, flip: 1'b0, exp_fe: 1'b1, exp_pe: 1'b0};
    vecs[2] = '{data: 8'h7E, stop: 1'b1, flip: 1'b1, exp_fe: 1'b0, exp_pe: 1'(PAR_EN)};
    vecs[3] = '{data: 8'h00, stop: 1'b0, flip: 1'b1, exp_fe: 1'b1, exp_pe: 1'(PAR_EN)};

    reset      = 1'b1;
    tx_valid   = 1'b0;
    tx_data    = '0;
    rx_ready   = 1'b1;
    rx_drv     = 1'b1;
    loop_en    = 1'b0;
    parity_odd = 1'b0;
    wait_clks(4);

    // reset state
    check("reset tx_out", 32'(tx_out), 32'(1));
    check("reset tx_ready", 32'(tx_ready), 32'(1));
    check("reset rx_valid", 32'(rx_valid), 32'(0));
    check("reset rx_data", 32'(rx_data), 32'(0));
    check("reset rx_frame_err", 32'(rx_frame_err), 32'(0));
    check("reset rx_parity_err", 32'(rx_parity_err), 32'(0));
    check("reset rx_overrun", 32'(rx_overrun), 32'(0));
    reset = 1'b0;
    wait_clks(10);

    // TX waveform of 0xA5, every clk of every bit
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) fb[i+1] = tx_data_bit(8'hA5, i);
    if (PAR_EN != 0) fb[DATA_W+1] = ^(8'hA5);
    for (int b = 0; b < FRAME_BITS; b++) bad[b] = 0;
    ready_low = 0;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    for (int k = 1; k <= FRAME_BITS * BIT_CLKS; k++) begin
      @(negedge clk);
      if (tx_out !== fb[(k-1)/BIT_CLKS]) bad[(k-1)/BIT_CLKS]++;
      if (!tx_ready) ready_low++;
    end
    for (int b = 0; b < FRAME_BITS; b++) check($sformatf("tx bit %0d bad clks", b), bad[b], 0);
    check("tx_ready low clks", ready_low, FRAME_BITS * BIT_CLKS);
    @(negedge clk);
    check("tx_ready after stop", 32'(tx_ready), 32'(1));
    wait_clks(10);

    // loopback, back-to-back
    loop_en = 1'b1;
    words0 = n_words;
    tx_send(8'h00, 1'b1);
    tx_send(8'hFF, 1'b1);
    tx_send(8'h3C, 1'b1);
    wait_drain("loopback drain");
    check("loopback word count", n_words - words0, 3);
    wait_clks(2 * BIT_CLKS);
    loop_en = 1'b0;
    wait_clks(10);

    // short low glitch must be rejected
    words0 = n_words;
    rx_drv = 1'b0;
    wait_clks(20);
    rx_drv = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("glitch produced no word", n_words - words0, 0);
    check("glitch rx_valid", 32'(rx_valid), 32'(0));

    // error-flag vectors
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back({vecs[v].exp_pe, vecs[v].exp_fe, vecs[v].data});
      rx_send(vecs[v].data, vecs[v].stop, vecs[v].flip);
      wait_drain($sformatf("vector %0d drain", v));
    end
    check("no overrun so far", n_overrun, 0);

    // overrun: two frames while consumer stalls
    @(negedge clk);
    rx_ready = 1'b0;
    ov0 = n_overrun;
    exp_q.push_back({2'b00, 8'h11});
    rx_send(8'h11, 1'b1, 1'b0);
    rx_send(8'h22, 1'b1, 1'b0);
    check("overrun pulses", n_overrun - ov0, 1);
    check("overrun rx_valid held", 32'(rx_valid), 32'(1));
    check("overrun keeps first word", 32'(rx_data), 32'(8'h11));
    rx_ready = 1'b1;
    wait_drain("overrun drain");
    wait_clks(10);

    // reset mid-frame on both paths, then a clean frame
    loop_en = 1'b1;
    tx_send(8'hC3, 1'b0);
    wait_clks(3 * BIT_CLKS);
    reset = 1'b1;
    @(negedge clk);
    check("midframe reset tx_out", 32'(tx_out), 32'(1));
    check("midframe reset tx_ready", 32'(tx_ready), 32'(1));
    check("midframe reset rx_valid", 32'(rx_valid), 32'(0));
    reset = 1'b0;
    wait_clks(5);
    words0 = n_words;
    tx_send(8'h5A, 1'b1);
    wait_drain("post-reset drain");
    check("post-reset word count", n_words - words0, 1);
    wait_clks(2 * BIT_CLKS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic tx_data_bit(input logic [7:0] d, input int i);
    return d[i];
  endfunction

endmodule
